keypad_scanner: RTL and testbench

//   Scans a 4x4 matrix keypad and produces the digit-entry strobes for the calculator input stage.

---
 rtl/keypad_scanner.sv | 263 ++++++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//   4x4 matrix keypad scanner feeding the calculator digit-entry stage.
//   Drives one active-low column at a time, synchronises the active-low rows
//   through two flops, debounces press and release, and emits a one-cycle
//   push (digit 0-9 on entrada) or guardar ('#') strobe per key event.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     When defined, a held digit key re-issues push every REPEAT_CYCLES cycles.
//     When undefined, no repeat logic is built.
//
//   Keymap [row][col], row/col 0 = bit 0:
//     r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter int unsigned SCAN_CYCLES     = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_CYCLES   = 4096
) (
  input  logic       clk,
  input  logic       rst,       // synchronous, active-low
  input  logic [3:0] filas,     // rows, active-low, asynchronous
  output logic [3:0] columnas,  // column drive, active-low one-hot
  output logic [3:0] entrada,   // last accepted digit
  output logic       push,      // one-cycle: new digit on entrada
  output logic       guardar    // one-cycle: '#' accepted
);

  // ---------------------------------------------------------------------------
  // Parameter sanity: the dwell must cover the two-flop row latency plus the
  // decision cycle, and the counters need at least one bit.
  // ---------------------------------------------------------------------------
  if (SCAN_CYCLES < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_params
    $error("keypad_scanner: SCAN_CYCLES>=4, DEBOUNCE_CYCLES>=2, REPEAT_CYCLES>=2 required");
  end

  localparam int DW  = $clog2(SCAN_CYCLES);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES);

  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] ROWS_IDLE = 4'b1111;
  localparam logic [3:0] COL_FIRST = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    FIRE     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef struct packed {
    logic       is_digit;
    logic       is_hash;
    logic [3:0] value;
  } key_t;

  // Decode a latched row pattern and the driven column into a key.
  // Patterns with zero or several low rows decode to "no key", which covers
  // ghosting and multi-key presses in the same column.
  function automatic key_t decode_key(input logic [3:0] pat, input logic [3:0] cols);
    key_t       k;
    logic [1:0] row;
    logic [1:0] col;
    logic       one_row;
    k       = '0;
    row     = 2'd0;
    col     = 2'd0;
    one_row = 1'b1;
    case (pat)
      4'b1110: row = 2'd0;
      4'b1101: row = 2'd1;
      4'b1011: row = 2'd2;
      4'b0111: row = 2'd3;
      default: one_row = 1'b0;
    endcase
    case (cols)
      4'b1110: col = 2'd0;
      4'b1101: col = 2'd1;
      4'b1011: col = 2'd2;
      4'b0111: col = 2'd3;
      default: col = 2'd0;
    endcase
    if (one_row) begin
      case ({row, col})
        4'd0:  begin k.is_digit = 1'b1; k.value = 4'd1; end
        4'd1:  begin k.is_digit = 1'b1; k.value = 4'd2; end
        4'd2:  begin k.is_digit = 1'b1; k.value = 4'd3; end
        4'd4:  begin k.is_digit = 1'b1; k.value = 4'd4; end
        4'd5:  begin k.is_digit = 1'b1; k.value = 4'd5; end
        4'd6:  begin k.is_digit = 1'b1; k.value = 4'd6; end
        4'd8:  begin k.is_digit = 1'b1; k.value = 4'd7; end
        4'd9:  begin k.is_digit = 1'b1; k.value = 4'd8; end
        4'd10: begin k.is_digit = 1'b1; k.value = 4'd9; end
        4'd13: begin k.is_digit = 1'b1; k.value = 4'd0; end
        4'd14: k.is_hash = 1'b1;
        default: k = '0;  // A, B, C, D, '*'
      endcase
    end
    return k;
  endfunction

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  logic [3:0]     fs1_q, fs_q;
  state_t         state_q, state_d;
  logic [3:0]     cols_q, cols_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic [DBW-1:0] dbc_q, dbc_d;
  logic [DBW-1:0] rel_q, rel_d;
  logic [3:0]     pattern_q, pattern_d;
  logic [3:0]     entrada_q, entrada_d;
  logic           push_q, push_d;
  logic           guardar_q, guardar_d;
  key_t           cur_key;

`ifdef AUTO_REPEAT_EN
  localparam int RPW = $clog2(REPEAT_CYCLES);
  localparam logic [RPW-1:0] REP_LAST = RPW'(REPEAT_CYCLES - 1);
  logic [RPW-1:0] rep_q, rep_d;
`endif

  // Key under the held column; valid while the column is parked.
  always_comb cur_key = decode_key(pattern_q, cols_q);

  // Row synchroniser and all FSM/datapath state, synchronous active-low reset.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would chain fs1_q straight into fs_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      fs1_q     <= ROWS_IDLE;
      fs_q      <= ROWS_IDLE;
      state_q   <= SCAN;
      cols_q    <= COL_FIRST;
      dwell_q   <= '0;
      dbc_q     <= '0;
      rel_q     <= '0;
      pattern_q <= ROWS_IDLE;
      entrada_q <= 4'd0;
      push_q    <= 1'b0;
      guardar_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_q     <= '0;
`endif
    end else begin
      fs1_q     <= filas;
      fs_q      <= fs1_q;
      state_q   <= state_d;
      cols_q    <= cols_d;
      dwell_q   <= dwell_d;
      dbc_q     <= dbc_d;
      rel_q     <= rel_d;
      pattern_q <= pattern_d;
      entrada_q <= entrada_d;
      push_q    <= push_d;
      guardar_q <= guardar_d;
`ifdef AUTO_REPEAT_EN
      rep_q     <= rep_d;
`endif
    end
  end

  // Next-state and registered-output logic. Strobes are computed one cycle
  // ahead so push/guardar (and the new entrada) are visible during FIRE.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    state_d   = state_q;
    cols_d    = cols_q;
    dwell_d   = dwell_q;
    dbc_d     = dbc_q;
    rel_d     = rel_q;
    pattern_d = pattern_q;
    entrada_d = entrada_q;
    push_d    = 1'b0;
    guardar_d = 1'b0;
`ifdef AUTO_REPEAT_EN
    rep_d     = rep_q;
`endif

    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          if (fs_q == ROWS_IDLE) begin
            cols_d  = {cols_q[2:0], cols_q[3]};
            dwell_d = '0;
          end else begin
            pattern_d = fs_q;
            dbc_d     = '0;
            state_d   = DEBOUNCE;
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (fs_q != pattern_q) begin
          state_d = SCAN;
          dwell_d = '0;
        end else if (dbc_q == DB_LAST) begin
          state_d = FIRE;
          if (cur_key.is_digit) begin
            push_d    = 1'b1;
            entrada_d = cur_key.value;
          end else if (cur_key.is_hash) begin
            guardar_d = 1'b1;
          end
        end else begin
          dbc_d = dbc_q + DBW'(1);
        end
      end

      FIRE: begin
        state_d = RELEASE;
        rel_d   = '0;
`ifdef AUTO_REPEAT_EN
        // FIRE itself is the first cycle of the repeat period.
        rep_d   = RPW'(1);
`endif
      end

      RELEASE: begin
        if (fs_q == ROWS_IDLE) begin
          if (rel_q == DB_LAST) begin
            state_d = SCAN;
            cols_d  = {cols_q[2:0], cols_q[3]};
            dwell_d = '0;
          end else begin
            rel_d = rel_q + DBW'(1);
          end
        end else begin
          rel_d = '0;
        end
`ifdef AUTO_REPEAT_EN
        if (fs_q == pattern_q) begin
          if (rep_q == REP_LAST) begin
            rep_d  = '0;
            push_d = cur_key.is_digit;
          end else begin
            rep_d = rep_q + RPW'(1);
          end
        end else begin
          rep_d = '0;
        end
`endif
      end

      default: begin
        state_d = SCAN;
        dwell_d = '0;
      end
    endcase
  end

  assign columnas = cols_q;
  assign entrada  = entrada_q;
  assign push     = push_q;
  assign guardar  = guardar_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//   Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8,
//   REPEAT_CYCLES=64. A behavioural keypad pulls a row low whenever a pressed
//   key sits in the currently driven column. Build with +define+AUTO_REPEAT_EN
//   to exercise the repeat variant.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

  localparam int SC = 4;
  localparam int DB = 8;
  localparam int RP = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] entrada;
  logic       push;
  logic       guardar;

  logic [15:0] press_mask = '0;  // bit r*4+c = key at row r, column c held

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int push_cnt = 0;
  int guardar_cnt = 0;
  logic [3:0] entrada_at_push = 4'd0;
  logic prev_push = 1'b0;
  logic prev_guardar = 1'b0;
  int push_time[$];

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CYCLES    (SC),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .filas   (filas),
    .columnas(columnas),
    .entrada (entrada),
    .push    (push),
    .guardar (guardar)
  );

  // Keypad matrix model: a row reads low if any held key of that row is in a
  // column currently driven low.
  always_comb begin
    filas = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (press_mask[r*4+c] && !columnas[c]) filas[r] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (push === 1'b1) begin
      push_cnt++;
      entrada_at_push = entrada;
      push_time.push_back(cyc);
    end
    if (guardar === 1'b1) guardar_cnt++;
    if (push === 1'b1 && guardar === 1'b1) begin
      errors++;
      $display("FAIL strobe_overlap: push=%b guardar=%b, required not both high (cycle %0d)", push, guardar, cyc);
    end
    if ((push === 1'b1 && prev_push) || (guardar === 1'b1 && prev_guardar)) begin
      errors++;
      $display("FAIL strobe_width: strobe high two cycles in a row, required one cycle (cycle %0d)", cyc);
    end
    prev_push    = (push === 1'b1);
    prev_guardar = (guardar === 1'b1);
  end

  // One clock: drive and sample just after the falling edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    push_cnt    = 0;
    guardar_cnt = 0;
    push_time.delete();
  endtask

  task automatic hold_key(input int r, input int c, input int cycles);
    press_mask          = '0;
    press_mask[r*4 + c] = 1'b1;
    tick(cycles);
    press_mask = '0;
    tick(30);
  endtask

  task automatic test_reset();
    logic [3:0] exp_cols;
    rst = 1'b0;
    tick(3);
    checks++;
    if (columnas !== 4'b1110) begin errors++; $display("FAIL reset_columnas: got %b, required 1110", columnas); end
    checks++;
    if (entrada !== 4'd0) begin errors++; $display("FAIL reset_entrada: got %0d, required 0", entrada); end
    checks++;
    if (push !== 1'b0) begin errors++; $display("FAIL reset_push: got %b, required 0", push); end
    checks++;
    if (guardar !== 1'b0) begin errors++; $display("FAIL reset_guardar: got %b, required 0", guardar); end
    clear_counts();
    rst = 1'b1;
    exp_cols = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      tick(SC);
      exp_cols = {exp_cols[2:0], exp_cols[3]};
      checks++;
      if (columnas !== exp_cols) begin
        errors++;
        $display("FAIL scan_rotate_%0d: got %b, required %b", i, columnas, exp_cols);
      end
    end
    checks++;
    if (push_cnt + guardar_cnt != 0) begin
      errors++;
      $display("FAIL idle_no_strobe: got %0d strobes, required 0", push_cnt + guardar_cnt);
    end
  endtask

  task automatic test_digit_5();
    clear_counts();
    hold_key(1, 1, 100);
    checks++;
    if (push_cnt != 1) begin errors++; $display("FAIL key5_push_count: got %0d, required 1", push_cnt); end
    checks++;
    if (entrada_at_push !== 4'd5) begin errors++; $display("FAIL key5_entrada_at_push: got %0d, required 5", entrada_at_push); end
    checks++;
    if (entrada !== 4'd5) begin errors++; $display("FAIL key5_entrada_held: got %0d, required 5", entrada); end
    checks++;
    if (guardar_cnt != 0) begin errors++; $display("FAIL key5_guardar: got %0d pulses, required 0", guardar_cnt); end
  endtask

  task automatic test_hash();
    clear_counts();
    hold_key(3, 2, 100);
    checks++;
    if (guardar_cnt != 1) begin errors++; $display("FAIL hash_guardar_count: got %0d, required 1", guardar_cnt); end
    checks++;
    if (push_cnt != 0) begin errors++; $display("FAIL hash_push: got %0d pulses, required 0", push_cnt); end
    checks++;
    if (entrada !== 4'd5) begin errors++; $display("FAIL hash_entrada: got %0d, required 5", entrada); end
  endtask

  task automatic test_bounce();
    int         changes;
    logic [3:0] last_cols;
    clear_counts();
    press_mask = '0;
    for (int i = 0; i < 20; i++) begin
      press_mask[2*4 + 0] = (i % 2 == 0);
      tick(3);
    end
    press_mask = '0;
    tick(10);
    checks++;
    if (push_cnt + guardar_cnt != 0) begin
      errors++;
      $display("FAIL bounce_no_strobe: got %0d strobes, required 0", push_cnt + guardar_cnt);
    end
    changes   = 0;
    last_cols = columnas;
    for (int i = 0; i < 16; i++) begin
      tick(1);
      if (columnas !== last_cols) changes++;
      last_cols = columnas;
    end
    checks++;
    if (changes != 4) begin errors++; $display("FAIL bounce_scan_resumes: got %0d column steps in 16 cycles, required 4", changes); end
    clear_counts();
    hold_key(2, 0, 100);
    checks++;
    if (push_cnt != 1) begin errors++; $display("FAIL key7_push_count: got %0d, required 1", push_cnt); end
    checks++;
    if (entrada !== 4'd7) begin errors++; $display("FAIL key7_entrada: got %0d, required 7", entrada); end
  endtask

  task automatic test_ghost_and_ignored();
    int  waited;
    clear_counts();
    press_mask           = '0;
    press_mask[0*4 + 0]  = 1'b1;
    press_mask[2*4 + 0]  = 1'b1;
    tick(100);
    press_mask = '0;
    tick(30);
    checks++;
    if (push_cnt + guardar_cnt != 0) begin errors++; $display("FAIL ghost_no_strobe: got %0d strobes, required 0", push_cnt + guardar_cnt); end
    hold_key(0, 3, 100);
    checks++;
    if (push_cnt + guardar_cnt != 0) begin errors++; $display("FAIL keyA_no_strobe: got %0d strobes, required 0", push_cnt + guardar_cnt); end
    checks++;
    if (entrada !== 4'd7) begin errors++; $display("FAIL ignored_entrada: got %0d, required 7", entrada); end

    // Reset while '9' is being debounced.
    waited = 0;
    while (columnas !== 4'b1011 && waited < 40) begin
      tick(1);
      waited++;
    end
    checks++;
    if (columnas !== 4'b1011) begin errors++; $display("FAIL wait_col2: timeout, columnas=%b, required 1011", columnas); end
    press_mask[2*4 + 2] = 1'b1;
    tick(7);
    rst = 1'b0;
    tick(3);
    checks++;
    if (columnas !== 4'b1110) begin errors++; $display("FAIL midreset_columnas: got %b, required 1110", columnas); end
    checks++;
    if (entrada !== 4'd0) begin errors++; $display("FAIL midreset_entrada: got %0d, required 0", entrada); end
    press_mask = '0;
    tick(1);
    rst = 1'b1;
    tick(40);
    checks++;
    if (push_cnt != 0) begin errors++; $display("FAIL midreset_no_push: got %0d, required 0", push_cnt); end
    checks++;
    if (entrada !== 4'd0) begin errors++; $display("FAIL midreset_entrada_after: got %0d, required 0", entrada); end
  endtask

  task automatic test_hold_repeat();
    int waited;
    clear_counts();
    press_mask          = '0;
    press_mask[0*4 + 2] = 1'b1;
    waited = 0;
    while (push_cnt == 0 && waited < 100) begin
      tick(1);
      waited++;
    end
    checks++;
    if (push_cnt != 1) begin errors++; $display("FAIL key3_accept: got %0d pushes within 100 cycles, required 1", push_cnt); end
    tick(200);
    press_mask = '0;
    tick(30);
`ifdef AUTO_REPEAT_EN
    checks++;
    if (push_cnt != 4) begin errors++; $display("FAIL key3_repeat_count: got %0d, required 4", push_cnt); end
    for (int i = 1; i < 4; i++) begin
      if (i < push_time.size()) begin
        checks++;
        if (push_time[i] - push_time[i-1] != RP) begin
          errors++;
          $display("FAIL key3_repeat_gap_%0d: got %0d cycles, required %0d", i, push_time[i] - push_time[i-1], RP);
        end
      end
    end
`else
    checks++;
    if (push_cnt != 1) begin errors++; $display("FAIL key3_single_push: got %0d, required 1", push_cnt); end
`endif
    checks++;
    if (entrada !== 4'd3) begin errors++; $display("FAIL key3_entrada: got %0d, required 3", entrada); end

    clear_counts();
    hold_key(3, 2, 300);
    checks++;
    if (guardar_cnt != 1) begin errors++; $display("FAIL hash_hold_guardar: got %0d, required 1", guardar_cnt); end
    checks++;
    if (push_cnt != 0) begin errors++; $display("FAIL hash_hold_push: got %0d, required 0", push_cnt); end
    checks++;
    if (entrada !== 4'd3) begin errors++; $display("FAIL hash_hold_entrada: got %0d, required 3", entrada); end
  endtask

  initial begin
    test_reset();
    test_digit_5();
    test_hash();
    test_bounce();
    test_ghost_and_ignored();
    test_hold_repeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
